// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding feeding the ALU.
// Held operands snoop WB writebacks while stalled so a retiring producer is never missed.
module id_ex_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_reg_write,
  input  logic [3:0]            id_alu_op,
  input  logic                  id_src_a_pc,
  input  logic                  id_src_b_imm,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]       mem_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]       wb_result,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       operand_a,
  output logic [XLEN-1:0]       operand_b,
  output logic [3:0]            alu_op,
  output logic [XLEN-1:0]       ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_write,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
);

  localparam logic [3:0] ALU_ADD = 4'h0;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  logic                  valid_q;
  logic [XLEN-1:0]       pc_q;
  logic [REG_ADDR_W-1:0] rs1_addr_q;
  logic [REG_ADDR_W-1:0] rs2_addr_q;
  logic [XLEN-1:0]       rs1_data_q;
  logic [XLEN-1:0]       rs2_data_q;
  logic [XLEN-1:0]       imm_q;
  logic [REG_ADDR_W-1:0] rd_addr_q;
  logic                  reg_write_q;
  logic [3:0]            alu_op_q;
  logic                  src_a_pc_q;
  logic                  src_b_imm_q;

  logic wb_snoop_rs1;
  logic wb_snoop_rs2;

  // x0 is never a real producer, so it must never be snooped.
  assign wb_snoop_rs1 = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs1_addr_q);
  assign wb_snoop_rs2 = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs2_addr_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
      alu_op_q    <= ALU_ADD;
      src_a_pc_q  <= 1'b0;
      src_b_imm_q <= 1'b0;
    end else if (stall) begin
      if (wb_snoop_rs1) rs1_data_q <= wb_result;
      if (wb_snoop_rs2) rs2_data_q <= wb_result;
    end else if (flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      alu_op_q    <= ALU_ADD;
      rd_addr_q   <= '0;
    end else begin
      valid_q     <= id_valid;
      pc_q        <= id_pc;
      rs1_addr_q  <= id_rs1_addr;
      rs2_addr_q  <= id_rs2_addr;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      rd_addr_q   <= id_rd_addr;
      reg_write_q <= id_reg_write;
      alu_op_q    <= id_alu_op;
      src_a_pc_q  <= id_src_a_pc;
      src_b_imm_q <= id_src_b_imm;
    end
  end

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fwd_rs1   = rs1_data_q;
    fwd_a_sel = FWD_REG;
    if (mem_reg_write && (mem_rd_addr == rs1_addr_q) && (rs1_addr_q != '0)) begin
      fwd_rs1   = mem_result;
      fwd_a_sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd_addr == rs1_addr_q) && (rs1_addr_q != '0)) begin
      fwd_rs1   = wb_result;
      fwd_a_sel = FWD_WB;
    end

    fwd_rs2   = rs2_data_q;
    fwd_b_sel = FWD_REG;
    if (mem_reg_write && (mem_rd_addr == rs2_addr_q) && (rs2_addr_q != '0)) begin
      fwd_rs2   = mem_result;
      fwd_b_sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd_addr == rs2_addr_q) && (rs2_addr_q != '0)) begin
      fwd_rs2   = wb_result;
      fwd_b_sel = FWD_WB;
    end
  end

  assign operand_a     = src_a_pc_q  ? pc_q  : fwd_rs1;
  assign operand_b     = src_b_imm_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_valid      = valid_q;
  assign alu_op        = alu_op_q;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_reg_write  = valid_q & reg_write_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage: reset, load, forwarding
// priority, x0 handling, stall snoop, stall/flush priority and operand muxing.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_reg_write, id_src_a_pc, id_src_b_imm;
  logic [3:0]  id_alu_op;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid, ex_reg_write;
  logic [31:0] operand_a, operand_b, ex_store_data;
  logic [3:0]  alu_op;
  logic [4:0]  ex_rd_addr;
  logic [1:0]  fwd_a_sel, fwd_b_sel;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .id_alu_op(id_alu_op), .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .ex_valid(ex_valid), .operand_a(operand_a), .operand_b(operand_b),
    .alu_op(alu_op), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc,
                        input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] a2, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [4:0] rd, input logic rw,
                        input logic [3:0] op, input logic sa, input logic sb);
    id_valid = v; id_pc = pc;
    id_rs1_addr = a1; id_rs1_data = d1;
    id_rs2_addr = a2; id_rs2_data = d2;
    id_imm = imm; id_rd_addr = rd; id_reg_write = rw;
    id_alu_op = op; id_src_a_pc = sa; id_src_b_imm = sb;
  endtask

  task automatic idle_fwd();
    mem_reg_write = 1'b0; mem_rd_addr = '0; mem_result = '0;
    wb_reg_write  = 1'b0; wb_rd_addr  = '0; wb_result  = '0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, ALU_ADD, 1'b0, 1'b0);
    idle_fwd();
    #12;
    rst = 1'b0;
    tick();

    // Async reset mid-cycle clears a loaded instruction without a clock edge.
    set_id(1'b1, 32'h100, 5'd1, 32'haaaa5555, 5'd2, 32'h12345678, 32'h0, 5'd4, 1'b1,
           ALU_SUB, 1'b0, 1'b0);
    tick();
    check("pre_rst_valid", {31'b0, ex_valid}, 32'd1);
    #3 rst = 1'b1;
    #1;
    check("rst_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_alu_op", {28'b0, alu_op}, {28'b0, ALU_ADD});
    check("rst_op_a", operand_a, 32'h0);
    check("rst_op_b", operand_b, 32'h0);
    check("rst_reg_write", {31'b0, ex_reg_write}, 32'd0);
    #1 rst = 1'b0;

    // Plain load, no hazards.
    set_id(1'b1, 32'h200, 5'd1, 32'h401e1042, 5'd2, 32'h7fffffff, 32'h0, 5'd3, 1'b1,
           ALU_SUB, 1'b0, 1'b0);
    tick();
    check("load_op_a", operand_a, 32'h401e1042);
    check("load_op_b", operand_b, 32'h7fffffff);
    check("load_sel_a", {30'b0, fwd_a_sel}, 32'd0);
    check("load_sel_b", {30'b0, fwd_b_sel}, 32'd0);
    check("load_alu_op", {28'b0, alu_op}, {28'b0, ALU_SUB});
    check("load_rd", {27'b0, ex_rd_addr}, 32'd3);
    check("load_reg_write", {31'b0, ex_reg_write}, 32'd1);

    // MEM beats WB on rs1 = x5; WB takes over once MEM drops.
    set_id(1'b1, 32'h204, 5'd5, 32'h0, 5'd6, 32'h22, 32'h0, 5'd7, 1'b1,
           ALU_ADD, 1'b0, 1'b0);
    tick();
    mem_reg_write = 1'b1; mem_rd_addr = 5'd5; mem_result = 32'hc41f1efb;
    wb_reg_write  = 1'b1; wb_rd_addr  = 5'd5; wb_result  = 32'h11111111;
    #1;
    check("mem_pri_op_a", operand_a, 32'hc41f1efb);
    check("mem_pri_sel_a", {30'b0, fwd_a_sel}, 32'd2);
    check("mem_pri_op_b", operand_b, 32'h22);
    mem_reg_write = 1'b0;
    #1;
    check("wb_op_a", operand_a, 32'h11111111);
    check("wb_sel_a", {30'b0, fwd_a_sel}, 32'd1);
    idle_fwd();

    // x0 source never forwards.
    set_id(1'b1, 32'h208, 5'd7, 32'h77, 5'd0, 32'h0, 32'h0, 5'd8, 1'b1,
           ALU_ADD, 1'b0, 1'b0);
    tick();
    mem_reg_write = 1'b1; mem_rd_addr = 5'd0; mem_result = 32'hdeadbeef;
    wb_reg_write  = 1'b1; wb_rd_addr  = 5'd0; wb_result  = 32'hcafef00d;
    #1;
    check("x0_op_b", operand_b, 32'h0);
    check("x0_sel_b", {30'b0, fwd_b_sel}, 32'd0);
    check("x0_op_a", operand_a, 32'h77);
    idle_fwd();

    // Three-cycle stall; WB retires rs1 in the second stalled cycle.
    set_id(1'b1, 32'h20c, 5'd9, 32'h1, 5'd10, 32'h2, 32'h0, 5'd12, 1'b1,
           ALU_SUB, 1'b0, 1'b0);
    tick();
    stall = 1'b1;
    set_id(1'b0, 32'hffff, 5'd13, 32'hbad0bad0, 5'd14, 32'hbad1bad1, 32'h0, 5'd15, 1'b0,
           ALU_ADD, 1'b1, 1'b1);
    tick();
    wb_reg_write = 1'b1; wb_rd_addr = 5'd9; wb_result = 32'h5980edb5;
    #1;
    check("snoop_fwd_a", operand_a, 32'h5980edb5);
    tick();
    idle_fwd();
    #1;
    check("snoop_held_a", operand_a, 32'h5980edb5);
    check("snoop_held_sel", {30'b0, fwd_a_sel}, 32'd0);
    check("snoop_held_b", operand_b, 32'h2);
    tick();
    check("stall_end_a", operand_a, 32'h5980edb5);
    check("stall_valid", {31'b0, ex_valid}, 32'd1);
    check("stall_rd", {27'b0, ex_rd_addr}, 32'd12);

    // Stall beats flush; flush alone makes a bubble.
    flush = 1'b1;
    tick();
    check("stflush_valid", {31'b0, ex_valid}, 32'd1);
    check("stflush_alu_op", {28'b0, alu_op}, {28'b0, ALU_SUB});
    stall = 1'b0;
    tick();
    check("flush_valid", {31'b0, ex_valid}, 32'd0);
    check("flush_reg_write", {31'b0, ex_reg_write}, 32'd0);
    check("flush_alu_op", {28'b0, alu_op}, {28'b0, ALU_ADD});
    check("flush_rd", {27'b0, ex_rd_addr}, 32'd0);
    flush = 1'b0;

    // Immediate and PC muxing; store data still follows forwarded rs2.
    set_id(1'b1, 32'h300, 5'd16, 32'h44, 5'd11, 32'h33, 32'hfffff800, 5'd17, 1'b0,
           ALU_ADD, 1'b1, 1'b1);
    tick();
    check("imm_op_b", operand_b, 32'hfffff800);
    check("imm_store", ex_store_data, 32'h33);
    check("pc_op_a", operand_a, 32'h300);
    check("imm_reg_write", {31'b0, ex_reg_write}, 32'd0);
    mem_reg_write = 1'b1; mem_rd_addr = 5'd11; mem_result = 32'h0000abcd;
    #1;
    check("imm_fwd_store", ex_store_data, 32'h0000abcd);
    check("imm_fwd_op_b", operand_b, 32'hfffff800);
    check("imm_fwd_sel_b", {30'b0, fwd_b_sel}, 32'd2);
    idle_fwd();

    // Reset while stalled drops held state at once.
    stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_stall_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_stall_op_a", operand_a, 32'h0);
    rst = 1'b0; stall = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
